// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed WIDTH-bit multiply / divide.
// Multiply: radix-2 shift-add on operand magnitudes, one bit per cycle.
// Divide: restoring division on magnitudes, one bit per cycle.
// A result is registered on the last iteration, and data_resultRDY pulses for
// the one DONE cycle that follows.
// Optional macro MULTDIV_RADIX4_EN: the multiply uses radix-4 modified Booth
// recoding on the signed operands, two bits per cycle (WIDTH/2 iterations).
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = $clog2(WIDTH) + 1;
`ifdef MULTDIV_RADIX4_EN
  localparam int MUL_STEPS = WIDTH / 2;
`else
  localparam int MUL_STEPS = WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, state_nx;
  logic             start;
  logic [CW-1:0]    cnt;
  logic             last_mul, last_div;
  logic             neg, dz, dovf;
  logic [WIDTH-1:0] mcand, dvsr, rem, quo;
  logic [WIDTH-1:0] diff, rem_nx, quo_nx, quot;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [2*WIDTH-1:0] prod;
  logic             mul_exc;
`ifdef MULTDIV_RADIX4_EN
  logic [2*WIDTH+2:0] r, r_nx;
  logic [WIDTH+1:0]   a_ext, addend, hi_sum;
`else
  logic [2*WIDTH-1:0] p, p_nx;
  logic [WIDTH:0]     mul_sum;
`endif

  // Two's complement magnitude; the most-negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  assign start    = ctrl_MULT | ctrl_DIV;
  assign last_mul = (cnt == CW'(MUL_STEPS - 1));
  assign last_div = (cnt == CW'(WIDTH - 1));
  assign data_resultRDY = (state == DONE);

`ifdef MULTDIV_RADIX4_EN
  // Booth step: recode {b[2k+1], b[2k], b[2k-1]} into -2..+2, add into the
  // high half, then arithmetic shift the whole accumulator right by two.
  always_comb begin
    a_ext = {{2{mcand[WIDTH-1]}}, mcand};
    unique case (r[2:0])
      3'b001, 3'b010: addend = a_ext;
      3'b011:         addend = a_ext << 1;
      3'b100:         addend = -(a_ext << 1);
      3'b101, 3'b110: addend = -a_ext;
      default:        addend = '0;
    endcase
    hi_sum = r[2*WIDTH+2:WIDTH+1] + addend;
    r_nx   = $signed({hi_sum, r[WIDTH:0]}) >>> 2;
    prod   = r_nx[2*WIDTH:1];
  end
`else
  // Shift-add step: conditionally add the multiplicand into the high half,
  // shift right; the multiplier drains out of the low half.
  always_comb begin
    mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mcand} : '0);
    p_nx    = {mul_sum, p[WIDTH-1:1]};
    prod    = neg ? -p_nx : p_nx;
  end
`endif

  // Signed overflow: the upper half plus the result sign bit must all agree.
  assign mul_exc = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));

  // Restoring divide step on magnitudes; the sign is applied to the final quotient.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    ge      = (shifted >= {1'b0, dvsr});
    diff    = shifted[WIDTH-1:0] - dvsr;
    rem_nx  = ge ? diff : shifted[WIDTH-1:0];
    quo_nx  = {quo[WIDTH-2:0], ge};
    quot    = neg ? -quo_nx : quo_nx;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: any start pulse restarts (MULT beats DIV), else iterate to DONE.
  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = ctrl_MULT ? MUL : DIV;
    end else begin
      unique case (state)
        IDLE:    state_nx = IDLE;
        MUL:     if (last_mul) state_nx = DONE;
        DIV:     if (last_div) state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Datapath: latch operands on start, iterate, register the result on the last step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt            <= '0;
      neg            <= 1'b0;
      dz             <= 1'b0;
      dovf           <= 1'b0;
      mcand          <= '0;
      dvsr           <= '0;
      rem            <= '0;
      quo            <= '0;
`ifdef MULTDIV_RADIX4_EN
      r              <= '0;
`else
      p              <= '0;
`endif
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      cnt  <= '0;
      neg  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dz   <= (data_operandB == '0);
      dovf <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
      dvsr <= mag(data_operandB);
      quo  <= mag(data_operandA);
      rem  <= '0;
`ifdef MULTDIV_RADIX4_EN
      mcand <= data_operandA;
      r     <= {{(WIDTH+2){1'b0}}, data_operandB, 1'b0};
`else
      mcand <= mag(data_operandA);
      p     <= {{WIDTH{1'b0}}, mag(data_operandB)};
`endif
    end else if (state == MUL) begin
`ifdef MULTDIV_RADIX4_EN
      r   <= r_nx;
`else
      p   <= p_nx;
`endif
      cnt <= cnt + 1'b1;
      if (last_mul) begin
        data_result    <= prod[WIDTH-1:0];
        data_exception <= mul_exc;
      end
    end else if (state == DIV) begin
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt + 1'b1;
      if (last_div) begin
        data_result    <= dz ? '0 : quot;
        data_exception <= dz | dovf;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed + random stimulus for multdiv_unit, with a
// scoreboard of expected result / exception / RDY cycle.
module tb_multdiv_unit;
  localparam int LAT_DIV = 32;
`ifdef MULTDIV_RADIX4_EN
  localparam int LAT_MUL = 16;
`else
  localparam int LAT_MUL = 32;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA = '0, data_operandB = '0;
  logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          at;
  } exp_t;
  exp_t sb[$];

  int total = 0, passed = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model of the arithmetic.
  function automatic void model(input bit mul, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint      pl;
    logic [63:0] pv;
    int          sa, sbv;
    sa = a; sbv = b;
    if (mul) begin
      pl = longint'(sa) * longint'(sbv);
      pv = pl;
      r  = pv[31:0];
      e  = !((pv[63:31] == '0) || (&pv[63:31]));
    end else if (b == 32'h0) begin
      r = 32'h0; e = 1'b1;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      r = 32'h80000000; e = 1'b1;
    end else begin
      r = sa / sbv; e = 1'b0;
    end
  endfunction

  // One-cycle start pulse; optionally push the expected completion.
  task automatic issue(input bit mul, input bit div, input logic [31:0] x,
                       input logic [31:0] y, input bit push);
    logic [31:0] r;
    logic        e;
    exp_t        t;
    model(mul, x, y, r, e);
    @(negedge clock);
    ctrl_MULT = mul; ctrl_DIV = div; data_operandA = x; data_operandB = y;
    if (push) begin
      t.res = r; t.exc = e; t.at = cyc + 1 + (mul ? LAT_MUL : LAT_DIV);
      sb.push_back(t);
    end
    @(negedge clock);
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
  endtask

  // Wait (bounded) for all outstanding completions.
  task automatic drain();
    int i;
    i = 0;
    while (sb.size() > 0 && i < 80) begin
      @(negedge clock); #1; i++;
    end
    chk("drain", sb.size(), 0);
  endtask

  // Monitor: every RDY pulse must match the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && data_resultRDY) begin
      if (sb.size() == 0) chk("spurious_rdy", data_resultRDY, 1'b0);
      else begin
        e = sb.pop_front();
        chk("result", data_result, e.res);
        chk("exception", data_exception, e.exc);
        chk("rdy_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] x, y;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_result", data_result, 32'h0);
    chk("rst_exc", data_exception, 1'b0);
    chk("rst_rdy", data_resultRDY, 1'b0);
    reset = 1'b0;

    issue(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 1'b1); drain();
    issue(1'b1, 1'b0, 32'h00010000, 32'h00010000, 1'b1); drain();
    issue(1'b1, 1'b0, 32'h7FFFFFFF, 32'd1, 1'b1); drain();
    issue(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b1); drain();
    issue(1'b0, 1'b1, 32'hFFFFFFEF, 32'd5, 1'b1); drain();
    issue(1'b0, 1'b1, 32'd100, 32'd0, 1'b1); drain();
    issue(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1); drain();
    issue(1'b1, 1'b1, 32'd6, 32'd3, 1'b1); drain();

    // Abort a divide with a multiply ten cycles in: only the multiply completes.
    issue(1'b0, 1'b1, 32'd1000, 32'd10, 1'b0);
    repeat (8) @(negedge clock);
    issue(1'b1, 1'b0, 32'd4, 32'd5, 1'b1); drain();

    // Start a divide during the DONE cycle of a multiply: both complete.
    issue(1'b1, 1'b0, 32'd2, 32'd3, 1'b1);
    repeat (LAT_MUL - 1) @(negedge clock);
    issue(1'b0, 1'b1, 32'hFFFFFFEC, 32'd3, 1'b1); drain();

    // Reset mid-multiply: outputs clear at once, no RDY afterwards.
    issue(1'b1, 1'b0, 32'd123, 32'd456, 1'b0);
    repeat (13) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midrst_result", data_result, 32'h0);
    chk("midrst_exc", data_exception, 1'b0);
    chk("midrst_rdy", data_resultRDY, 1'b0);
    @(negedge clock); reset = 1'b0;
    repeat (40) @(negedge clock);
    issue(1'b0, 1'b1, 32'd9, 32'd3, 1'b1); drain();

    for (int i = 0; i < 6; i++) begin
      x = $urandom;
      y = (i % 3 == 0) ? 32'($urandom_range(1, 100)) : $urandom;
      if (i % 2 == 0) issue(1'b1, 1'b0, x, y, 1'b1);
      else            issue(1'b0, 1'b1, x, y, 1'b1);
      drain();
    end

    repeat (5) @(negedge clock);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
